// File: rtl/shop_cmd_issuer.sv
// Host-side initiator for the shop: assembles "<hex uid><cmd chars>\n" lines into o_u/o_a
// and fires a one-cycle o_rdy strobe after one setup cycle, then idles for GAP_CYCLES.
module shop_cmd_issuer #(
    parameter int I_A_NUM_ASCII_CHARS = 7,
    parameter int I_A_NUM_BITS        = I_A_NUM_ASCII_CHARS * 8,
    parameter int I_U_NUM_BITS        = 4,
    parameter int GAP_CYCLES          = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_byte,
    input  logic                    i_byte_vld,
    output logic                    o_byte_rdy,
    output logic                    o_rdy,
    output logic [I_U_NUM_BITS-1:0] o_u,
    output logic [I_A_NUM_BITS-1:0] o_a,
    output logic                    o_err,
    output logic [7:0]              o_cmd_cnt
);

    localparam int CNT_W = $clog2(I_A_NUM_ASCII_CHARS + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(I_A_NUM_ASCII_CHARS);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]       LF       = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_FLUSH, S_SETUP, S_ISSUE, S_GAP
    } state_t;

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] b);
        if (b <= 8'h39)      return 4'(b - 8'h30);
        else if (b <= 8'h46) return 4'(b - 8'h37);
        else                 return 4'(b - 8'h57);
    endfunction

    state_t                  state_q, state_d;
    logic [I_U_NUM_BITS-1:0] u_buf_q, u_buf_d;
    logic [I_A_NUM_BITS-1:0] a_buf_q, a_buf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [I_U_NUM_BITS-1:0] u_q, u_d;
    logic [I_A_NUM_BITS-1:0] a_q, a_d;
    logic                    rdy_q, rdy_d;
    logic                    err_q, err_d;
    logic                    byte_rdy_q, byte_rdy_d;
    logic [7:0]              cmd_cnt_q, cmd_cnt_d;
    logic                    take;

    assign take = i_byte_vld & byte_rdy_q;

    always_comb begin
        state_d   = state_q;
        u_buf_d   = u_buf_q;
        a_buf_d   = a_buf_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        u_d       = u_q;
        a_d       = a_q;
        rdy_d     = 1'b0;
        err_d     = 1'b0;
        cmd_cnt_d = cmd_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (take && i_byte != LF) begin
                    if (is_hex(i_byte)) begin
                        u_buf_d = I_U_NUM_BITS'(hex_val(i_byte));
                        a_buf_d = '0;
                        cnt_d   = '0;
                        state_d = S_CMD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_CMD: begin
                if (take) begin
                    if (i_byte == LF) begin
                        if (cnt_q != '0) begin
                            u_d     = u_buf_q;
                            a_d     = a_buf_q;
                            state_d = S_SETUP;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (cnt_q < CNT_MAX) begin
                        // Right-aligned packing, same layout as a Verilog string literal
                        a_buf_d = {a_buf_q[I_A_NUM_BITS-9:0], i_byte};
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (take && i_byte == LF) state_d = S_IDLE;
            end
            S_SETUP: begin
                rdy_d   = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cmd_cnt_d = cmd_cnt_q + 8'd1;
                gap_d     = '0;
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        byte_rdy_d = (state_d == S_IDLE) || (state_d == S_CMD) || (state_d == S_FLUSH);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            u_buf_q    <= '0;
            a_buf_q    <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            u_q        <= '0;
            a_q        <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            byte_rdy_q <= 1'b1;
            cmd_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            u_buf_q    <= u_buf_d;
            a_buf_q    <= a_buf_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            u_q        <= u_d;
            a_q        <= a_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            byte_rdy_q <= byte_rdy_d;
            cmd_cnt_q  <= cmd_cnt_d;
        end
    end

    assign o_byte_rdy = byte_rdy_q;
    assign o_rdy      = rdy_q;
    assign o_u        = u_q;
    assign o_a        = a_q;
    assign o_err      = err_q;
    assign o_cmd_cnt  = cmd_cnt_q;

endmodule

// File: tb/tb_shop_cmd_issuer.sv
// Scoreboard bench for shop_cmd_issuer: a line-level reference model predicts strobes and
// error pulses (with their cycle), and a monitor pops and compares as the DUT produces them.
module tb_shop_cmd_issuer;

    localparam int GAP   = 4;
    localparam int K_CMD = 1;
    localparam int K_ERR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        vld = 1'b0;
    logic        o_byte_rdy, o_rdy, o_err;
    logic [3:0]  o_u;
    logic [55:0] o_a;
    logic [7:0]  o_cmd_cnt;

    shop_cmd_issuer #(
        .I_A_NUM_ASCII_CHARS(7), .I_A_NUM_BITS(56), .I_U_NUM_BITS(4), .GAP_CYCLES(GAP)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_byte(i_byte), .i_byte_vld(vld),
        .o_byte_rdy(o_byte_rdy), .o_rdy(o_rdy), .o_u(o_u), .o_a(o_a),
        .o_err(o_err), .o_cmd_cnt(o_cmd_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          cyc;
        logic [3:0]  u;
        logic [55:0] a;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] cur_line[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         issued = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit tb_is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic logic [3:0] tb_hex(input logic [7:0] c);
        int v;
        if (c <= 8'h39)      v = int'(c) - 48;
        else if (c <= 8'h46) v = int'(c) - 65 + 10;
        else                 v = int'(c) - 97 + 10;
        return 4'(v);
    endfunction

    // Line-level model: what a complete line should produce and which byte triggers it
    task automatic analyze(output int kind, output int epos, output logic [3:0] u,
                           output logic [55:0] a);
        int nch;
        kind = 0; epos = 0; u = 4'h0; a = 56'h0;
        nch = cur_line.size() - 2;
        if (cur_line.size() == 1) kind = 0;
        else if (!tb_is_hex(cur_line[0])) begin kind = K_ERR; epos = 0; end
        else if (nch == 0) begin kind = K_ERR; epos = 1; end
        else if (nch > 7) begin kind = K_ERR; epos = 8; end
        else begin
            kind = K_CMD;
            u = tb_hex(cur_line[0]);
            for (int i = 1; i <= nch; i++) a = (a << 8) | 56'(cur_line[i]);
        end
    endtask

    task automatic set_line(input string s);
        cur_line.delete();
        for (int i = 0; i < s.len(); i++) cur_line.push_back(s[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        i_byte = b;
        vld = 1'b1;
        while (!o_byte_rdy) begin
            @(negedge clk);
            w++;
            if (w > 100) begin
                n_fail++;
                $display("FAIL byte_rdy_timeout: o_byte_rdy=0 for %0d cycles, required 1 within 100", w);
                $fatal(1, "byte handshake stalled");
            end
        end
        @(negedge clk);
    endtask

    task automatic run_line(input bit hold, input bit gaps);
        int kind, epos;
        logic [3:0] u;
        logic [55:0] a;
        ev_t e;
        analyze(kind, epos, u, a);
        for (int i = 0; i < cur_line.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                vld = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            send_byte(cur_line[i]);
            if (kind == K_ERR && i == epos) begin
                e.kind = K_ERR; e.cyc = cyc; e.u = 4'h0; e.a = 56'h0;
                evq.push_back(e);
            end
            if (kind == K_CMD && i == cur_line.size() - 1) begin
                e.kind = K_CMD; e.cyc = cyc + 1; e.u = u; e.a = a;
                evq.push_back(e);
                issued++;
            end
        end
        if (!hold) vld = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((evq.size() != 0 || !o_byte_rdy) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending_events", 64'(evq.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [7:0] rchar();
        logic [7:0] c;
        do c = 8'($urandom_range(0, 255)); while (c == 8'h0A);
        return c;
    endfunction

    task automatic gen_line();
        string hx;
        logic [7:0] c;
        int r;
        hx = "0123456789ABCDEFabcdef";
        cur_line.delete();
        r = $urandom_range(0, 9);
        if (r == 1) begin
            do c = rchar(); while (tb_is_hex(c));
            cur_line.push_back(c);
            repeat ($urandom_range(0, 4)) cur_line.push_back(rchar());
        end else if (r != 0) begin
            cur_line.push_back(hx[$urandom_range(0, 21)]);
            if (r == 3) repeat ($urandom_range(8, 10)) cur_line.push_back(rchar());
            else if (r != 2) repeat ($urandom_range(1, 7)) cur_line.push_back(rchar());
        end
        cur_line.push_back(8'h0A);
    endtask

    // Monitor: pops the scoreboard on every strobe / error pulse, tracks held outputs
    initial begin : monitor
        ev_t e;
        logic [7:0]  exp_cnt;
        logic [3:0]  eu;
        logic [55:0] ea;
        int low;
        exp_cnt = 8'd0; eu = 4'h0; ea = 56'h0; low = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                exp_cnt = 8'd0; eu = 4'h0; ea = 56'h0; low = 0;
            end else begin
                if (o_err) begin
                    if (evq.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL spurious_err: o_err=1 at cycle %0d, none expected", cyc);
                    end else begin
                        e = evq.pop_front();
                        check("err_kind", 64'(K_ERR), 64'(e.kind));
                        check("err_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (o_rdy) begin
                    if (evq.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL spurious_rdy: o_rdy=1 at cycle %0d, none expected", cyc);
                    end else begin
                        e = evq.pop_front();
                        check("rdy_kind", 64'(K_CMD), 64'(e.kind));
                        check("rdy_cycle", 64'(cyc), 64'(e.cyc));
                        check("strobe_o_u", 64'(o_u), 64'(e.u));
                        check("strobe_o_a", 64'(o_a), 64'(e.a));
                        eu = e.u; ea = e.a;
                    end
                    check("cnt_at_strobe", 64'(o_cmd_cnt), 64'(exp_cnt));
                    exp_cnt = exp_cnt + 8'd1;
                end else begin
                    check("o_cmd_cnt", 64'(o_cmd_cnt), 64'(exp_cnt));
                end
                if (o_byte_rdy) begin
                    check("held_o_u", 64'(o_u), 64'(eu));
                    check("held_o_a", 64'(o_a), 64'(ea));
                    if (low != 0) check("byte_rdy_low_len", 64'(low), 64'(2 + GAP));
                    low = 0;
                end else begin
                    low++;
                end
            end
        end
    end

    initial begin : driver
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_byte_rdy", 64'(o_byte_rdy), 64'(1));
        check("rst_rdy", 64'(o_rdy), 64'(0));
        check("rst_err", 64'(o_err), 64'(0));
        check("rst_u", 64'(o_u), 64'(0));
        check("rst_a", 64'(o_a), 64'(0));
        check("rst_cnt", 64'(o_cmd_cnt), 64'(0));
        @(negedge clk);

        set_line("4Login\n");    run_line(0, 0); wait_idle();
        check("login_cnt", 64'(o_cmd_cnt), 64'(1));
        set_line("5AddItem\n");  run_line(0, 0); wait_idle();
        set_line("5AddItemX\n"); run_line(0, 0); wait_idle();
        set_line("6Buy\n");      run_line(1, 0);
        set_line("7hi\n");       run_line(0, 0); wait_idle();
        set_line("Gx\n");        run_line(0, 0); wait_idle();
        set_line("3\n");         run_line(0, 0); wait_idle();
        set_line("\n");          run_line(0, 0); wait_idle();
        check("directed_cnt", 64'(o_cmd_cnt), 64'(4));

        // Reset in the middle of a command line
        set_line("2Del");
        for (int i = 0; i < cur_line.size(); i++) send_byte(cur_line[i]);
        vld = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_byte_rdy", 64'(o_byte_rdy), 64'(1));
        check("midrst_rdy", 64'(o_rdy), 64'(0));
        check("midrst_err", 64'(o_err), 64'(0));
        check("midrst_u", 64'(o_u), 64'(0));
        check("midrst_a", 64'(o_a), 64'(0));
        check("midrst_cnt", 64'(o_cmd_cnt), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issued = 0;
        @(negedge clk);
        set_line("1DelUsr\n");   run_line(0, 0); wait_idle();
        check("post_rst_cnt", 64'(o_cmd_cnt), 64'(1));

        for (int n = 0; n < 800 && issued < 260; n++) begin
            gen_line();
            run_line(1'($urandom_range(0, 1)), 1'b1);
        end
        vld = 1'b0;
        wait_idle();
        check("final_cnt_wrapped", 64'(o_cmd_cnt), 64'(8'(issued)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
